// File: rtl/sdu_pkg.sv
// Shared UART constants, transmitter state encoding and a width helper for the SDU link.
package sdu_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdu_tx_fifo.sv
// Byte FIFO between the SDU print path and the bit engine: synchronous write, registered read.
module sdu_tx_fifo
  import sdu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  // Storage kept free of reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign count   = r_count;
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);

endmodule

// File: rtl/sdu_print_tx.sv
// SDU UART transmitter: FIFO-buffered 8N1 framer with registered txd.
// Define SDU_TX_PARITY_EN to insert an even-parity bit between data and stop.
module sdu_print_tx
  import sdu_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_vld,
  output logic                          din_rdy,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int CW  = clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("sdu_print_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("sdu_print_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  tx_state_t     r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_txd, w_txd_next;
  logic          r_rdy_en;
  logic          w_tick;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_fifo_rdata;
  logic [CW:0]   w_fifo_cnt;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  sdu_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (din),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rdata),
    .count   (w_fifo_cnt),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // r_rdy_en holds din_rdy low until the first edge after reset release.
  assign din_rdy  = r_rdy_en && !w_fifo_full;
  assign w_push   = din_vld && din_rdy;
  assign w_tick   = (r_timer == TICK_LAST);
  assign txd      = r_txd;
  assign busy     = (r_state != IDLE) || !w_fifo_empty;
  assign fifo_cnt = w_fifo_cnt;

  always_comb begin
    w_state_next = r_state;
    w_timer_next = w_tick ? '0 : r_timer + TW'(1);
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_txd_next   = r_txd;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        w_txd_next   = IDLE_LVL;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
          w_txd_next   = START_LVL;
        end
      end
      START: begin
        // The popped byte is valid in the read register for the whole start bit.
        if (w_tick) begin
          w_state_next = DATA;
          w_idx_next   = '0;
          w_shift_next = w_fifo_rdata;
          w_txd_next   = w_fifo_rdata[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == IDX_LAST) begin
`ifdef SDU_TX_PARITY_EN
            w_state_next = PARITY;
            w_txd_next   = ^r_shift;
`else
            w_state_next = STOP;
            w_txd_next   = STOP_LVL;
`endif
          end else begin
            w_idx_next = r_idx + 3'd1;
            w_txd_next = r_shift[w_idx_next];
          end
        end
      end
      PARITY: begin
`ifdef SDU_TX_PARITY_EN
        if (w_tick) begin
          w_state_next = STOP;
          w_txd_next   = STOP_LVL;
        end
`else
        w_state_next = IDLE;
        w_txd_next   = IDLE_LVL;
`endif
      end
      STOP: begin
        if (w_tick) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
            w_txd_next   = START_LVL;
          end else begin
            w_state_next = IDLE;
            w_txd_next   = IDLE_LVL;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_txd_next   = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_txd    <= IDLE_LVL;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_idx    <= w_idx_next;
      r_shift  <= w_shift_next;
      r_txd    <= w_txd_next;
      r_rdy_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdu_print_tx.sv
// Directed + randomized bench for sdu_print_tx: a line-level frame decoder and a byte queue model.
module tb_sdu_print_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef SDU_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       din_rdy;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int blocked = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_ok;
    logic       stop_ok;
    int         start;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];

  sdu_print_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .txd      (txd),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  // Line decoder: a frame begins at the first negedge txd is seen low, bits sampled mid-bit.
  initial begin
    frame_t f;
    bit     aborted;
    int     j;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        f.start = cyc;
        f.data = 8'h00;
        f.par = 1'b0;
        f.start_ok = 1'b0;
        f.stop_ok = 1'b0;
        aborted = 1'b0;
        for (int k = 1; k <= (NB - 1) * DIV + DIV / 2; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (k % DIV == DIV / 2) begin
            j = k / DIV;
            if (j == 0) f.start_ok = (txd === 1'b0);
            else if (j <= 8) f.data[j-1] = txd;
            else if (j == NB - 1) f.stop_ok = (txd === 1'b1);
            else f.par = txd;
          end
        end
        if (!aborted) rx_q.push_back(f);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    int guard = 0;
    din = b;
    din_vld = 1'b1;
    while (din_rdy !== 1'b1 && guard < 2000) begin
      if (fifo_cnt === 3'd4) blocked++;
      @(negedge clk);
      guard++;
    end
    chk("send_accept", din_rdy, 1);
    @(negedge clk);
    acc = cyc;
    exp_q.push_back(b);
    din_vld = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (rx_q.size() < n && guard < (n + 3) * FRAME * 3) begin
      @(negedge clk);
      guard++;
    end
    chk("frames_rx", rx_q.size(), n);
  endtask

  task automatic check_frame(input string tag, output int start);
    frame_t     f;
    logic [7:0] e;
    f = rx_q.pop_front();
    e = exp_q.pop_front();
    chk({tag, "_data"}, f.data, e);
    chk({tag, "_framing"}, {f.start_ok, f.stop_ok}, 2'b11);
`ifdef SDU_TX_PARITY_EN
    chk({tag, "_parity"}, f.par, ^e);
`endif
    start = f.start;
    $display("[TB] %s: byte 0x%02h expected 0x%02h start cycle %0d", tag, f.data, e, f.start);
  endtask

  initial begin
    int a, a2, d, s, s2;
    logic [7:0] b;

    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("din_rdy_after_rst", din_rdy, 1);

    // Single 0x55 into an idle block
    send(8'h55, a);
    chk("t1_cnt_one", fifo_cnt, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_cnt_zero", fifo_cnt, 0);
    chk("t1_txd_start", txd, 0);
    wait_frames(1);
    check_frame("t1", s);
    chk("t1_latency", s, a + 1);
    wait_until(s + FRAME - 1);
    chk("t1_busy_last", busy, 1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 0);
    chk("t1_txd_idle", txd, 1);

    // Three bytes back-to-back: zero idle gap
    send(8'h01, a);
    send(8'h02, d);
    send(8'h03, d);
    wait_frames(3);
    check_frame("t2_0", s);
    chk("t2_latency", s, a + 1);
    for (int i = 1; i < 3; i++) begin
      check_frame("t2_n", s2);
      chk("t2_gap", s2 - s, FRAME);
      s = s2;
    end
    wait_until(s + FRAME + 1);
    chk("t2_idle", busy, 0);

    // Six bytes held against a depth-4 FIFO
    blocked = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), d);
      if (i == 4) begin
        chk("t3_full_cnt", fifo_cnt, 4);
        chk("t3_full_rdy", din_rdy, 0);
      end
    end
    chk("t3_backpressure_seen", (blocked > 0), 1);
    wait_frames(6);
    check_frame("t3_0", s);
    for (int i = 1; i < 6; i++) begin
      check_frame("t3_n", s2);
      chk("t3_gap", s2 - s, FRAME);
      s = s2;
    end
    wait_until(s + FRAME + 1);
    chk("t3_idle", busy, 0);

    // Push landing on the pop edge at the end of STOP with two bytes queued
    send(8'($urandom_range(0, 255)), a);
    send(8'($urandom_range(0, 255)), d);
    send(8'($urandom_range(0, 255)), d);
    s = a + 1;
    wait_until(s + FRAME - 1);
    chk("t4_cnt_before", fifo_cnt, 2);
    send(8'($urandom_range(0, 255)), a2);
    chk("t4_accept_cycle", a2, s + FRAME);
    chk("t4_cnt_held", fifo_cnt, 2);
    wait_frames(4);
    check_frame("t4_0", s2);
    chk("t4_latency", s2, s);
    for (int i = 1; i < 4; i++) begin
      check_frame("t4_n", s2);
      chk("t4_gap", s2 - s, FRAME);
      s = s2;
    end
    wait_until(s + FRAME + 1);
    chk("t4_idle", busy, 0);

    // Reset 35 clocks into a 0xA3 frame with another byte still queued
    send(8'hA3, a);
    send(8'($urandom_range(0, 255)), d);
    wait_until(a + 1 + 35);
    rst = 1'b1;
    #1;
    chk("t5_rst_txd", txd, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", fifo_cnt, 0);
    chk("t5_rst_rdy", din_rdy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_truncated_dropped", rx_q.size(), 0);
    send(8'h3C, a);
    wait_frames(1);
    check_frame("t5", s);
    chk("t5_latency", s, a + 1);
    wait_until(s + FRAME + 50);
    chk("t5_no_extra_frame", rx_q.size(), 0);
    chk("t5_idle", busy, 0);

`ifdef SDU_TX_PARITY_EN
    send(8'h07, d);
    send(8'h03, d);
    wait_frames(2);
    check_frame("par_07", s);
    check_frame("par_03", s2);
    chk("par_frame_len", s2 - s, 110);
`endif

    // Random bytes with random gaps
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, d);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    wait_frames(8);
    for (int i = 0; i < 8; i++) check_frame("rnd", s);
    wait_until(s + FRAME + 1);
    chk("rnd_idle", busy, 0);
    chk("rnd_cnt", fifo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
